// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch and load/store.
// Latency: request sampled in IDLE -> bus driven next cycle; valid >= 2 cycles after request.
// Backpressure: requests are held until their valid pulse; BACK_n stalls up to TIMEOUT cycles.
module mem_bus_arbiter #(
    parameter int BIT_WIDTH    = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic [BIT_WIDTH-1:0] i_addr,
    output logic [BIT_WIDTH-1:0] i_rdata,
    output logic                 i_valid,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic [BIT_WIDTH-1:0] d_addr,
    input  logic [BIT_WIDTH-1:0] d_wdata,
    output logic [BIT_WIDTH-1:0] d_rdata,
    output logic                 d_valid,

    output logic                 err,

    output logic [BIT_WIDTH-1:0] BAD,
    output logic                 BREQ,
    output logic                 BWRITE,
    output logic [1:0]           BSIZE,
    output logic [BIT_WIDTH-1:0] BWDT,
    input  logic [BIT_WIDTH-1:0] BRDT,
    input  logic                 BACK_n
);

    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam int TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] addr;
        logic [1:0]           size;
        logic                 we;
        logic [BIT_WIDTH-1:0] wdata;
    } bus_req_t;

    state_t               state;
    state_t               state_nxt;
    logic [STREAK_W-1:0]  streak;
    logic [TMO_W-1:0]     tmo_cnt;

    logic                 grant_i;
    logic                 grant_d;
    logic                 ack_done;
    logic                 tmo_done;
    bus_req_t             req_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        ack_done  = 1'b0;
        tmo_done  = 1'b0;
        req_sel   = '0;

        case (state)
            IDLE: begin
                // Data wins unless it has starved a waiting fetch for a full streak.
                if (d_req && (!i_req || (streak < STREAK_MAX))) begin
                    grant_d   = 1'b1;
                    state_nxt = DBUS;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = IBUS;
                end
            end
            IBUS, DBUS: begin
                if (!BACK_n) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (grant_d) begin
            req_sel.addr  = d_addr;
            req_sel.size  = d_size;
            req_sel.we    = d_we;
            req_sel.wdata = d_wdata;
        end else if (grant_i) begin
            req_sel.addr  = i_addr;
            req_sel.size  = 2'b00;
            req_sel.we    = 1'b0;
            req_sel.wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak  <= '0;
            tmo_cnt <= '0;
            BAD     <= '0;
            BREQ    <= 1'b0;
            BWRITE  <= 1'b0;
            BSIZE   <= 2'b00;
            BWDT    <= '0;
            i_rdata <= '0;
            i_valid <= 1'b0;
            d_rdata <= '0;
            d_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;

            if (grant_i || grant_d) begin
                BAD     <= req_sel.addr;
                BSIZE   <= req_sel.size;
                BWRITE  <= req_sel.we;
                BWDT    <= req_sel.wdata;
                BREQ    <= 1'b1;
                tmo_cnt <= '0;
            end

            if (grant_i) begin
                streak <= '0;
            end else if (grant_d) begin
                if (!i_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end

            if ((state != IDLE) && BACK_n) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (ack_done || tmo_done) begin
                BREQ   <= 1'b0;
                BWRITE <= 1'b0;
                err    <= tmo_done;
                if (state == IBUS) begin
                    i_valid <= 1'b1;
                    i_rdata <= tmo_done ? '0 : BRDT;
                end else begin
                    d_valid <= 1'b1;
                    // Stores leave the last load result in place.
                    if (tmo_done) begin
                        d_rdata <= '0;
                    end else if (!BWRITE) begin
                        d_rdata <= BRDT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change and outputs are checked on the falling edge.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        err;
    logic [31:0] BAD;
    logic        BREQ;
    logic        BWRITE;
    logic [1:0]  BSIZE;
    logic [31:0] BWDT;
    logic [31:0] BRDT;
    logic        BACK_n;

    int total;
    int bad;

    mem_bus_arbiter #(
        .BIT_WIDTH    (32),
        .MAX_D_STREAK (4),
        .TIMEOUT      (255)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_valid (i_valid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .err     (err),
        .BAD     (BAD),
        .BREQ    (BREQ),
        .BWRITE  (BWRITE),
        .BSIZE   (BSIZE),
        .BWDT    (BWDT),
        .BRDT    (BRDT),
        .BACK_n  (BACK_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        BRDT = '0; BACK_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({BREQ, BWRITE, BSIZE, i_valid, d_valid, err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {BREQ, BWRITE, BSIZE, i_valid, d_valid, err});
        end
        total++;
        if ({BAD, BWDT, i_rdata, d_rdata} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {BAD, BWDT, i_rdata, d_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (BREQ !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_breq got=%b exp=0", BREQ);
        end
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        @(negedge clk);
        total++;
        if ({BREQ, BWRITE, BSIZE, BAD} !== {1'b1, 1'b0, 2'b00, 32'h10}) begin
            bad++;
            $display("FAIL fetch_bus got=%b/%b/%b/%h exp=1/0/00/00000010", BREQ, BWRITE, BSIZE, BAD);
        end
        BACK_n = 1'b0; BRDT = 32'h2008_0001;
        @(negedge clk);
        total++;
        if ({i_valid, d_valid, err, BREQ} !== 4'b1000) begin
            bad++;
            $display("FAIL fetch_valid got=i%b d%b e%b breq%b exp=1000", i_valid, d_valid, err, BREQ);
        end
        total++;
        if (i_rdata !== 32'h2008_0001) begin
            bad++;
            $display("FAIL fetch_rdata got=%h exp=20080001", i_rdata);
        end
        i_req = 1'b0; BACK_n = 1'b1; BRDT = '0;
        @(negedge clk);
        total++;
        if ({i_valid, BREQ} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_pulse_end got=%b exp=00", {i_valid, BREQ});
        end
    endtask

    task automatic test_load_delayed_ack();
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0100;
        @(negedge clk);
        total++;
        if ({BREQ, BWRITE, BAD} !== {1'b1, 1'b0, 32'h100}) begin
            bad++;
            $display("FAIL load_bus got=%b/%b/%h exp=1/0/00000100", BREQ, BWRITE, BAD);
        end
        @(negedge clk);
        total++;
        if ({d_valid, BREQ} !== 2'b01) begin
            bad++;
            $display("FAIL load_wait got=%b exp=01", {d_valid, BREQ});
        end
        BACK_n = 1'b0; BRDT = 32'hCAFE_BABE;
        @(negedge clk);
        total++;
        if ({d_valid, i_valid, err} !== 3'b100 || d_rdata !== 32'hCAFE_BABE) begin
            bad++;
            $display("FAIL load_done got=%b/%h exp=100/cafebabe", {d_valid, i_valid, err}, d_rdata);
        end
        d_req = 1'b0; BACK_n = 1'b1;
        @(negedge clk);
        total++;
        if (d_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_pulse_end got=%b exp=0", d_valid);
        end
    endtask

    task automatic test_store_byte();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'hF000_0000; d_wdata = 32'h41;
        @(negedge clk);
        total++;
        if ({BREQ, BWRITE, BSIZE, BAD, BWDT} !== {1'b1, 1'b1, 2'b10, 32'hF000_0000, 32'h41}) begin
            bad++;
            $display("FAIL store_bus got=%b/%b/%b/%h/%h exp=1/1/10/f0000000/00000041",
                     BREQ, BWRITE, BSIZE, BAD, BWDT);
        end
        BACK_n = 1'b0; BRDT = 32'h1234_5678;
        @(negedge clk);
        total++;
        if ({d_valid, BREQ, BWRITE} !== 3'b100) begin
            bad++;
            $display("FAIL store_done got=%b exp=100", {d_valid, BREQ, BWRITE});
        end
        total++;
        if (d_rdata !== 32'hCAFE_BABE) begin
            bad++;
            $display("FAIL store_rdata_kept got=%h exp=cafebabe", d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; BACK_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_streak();
        logic exp_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        int both;
        n = 0;
        both = 0;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800;
        BACK_n = 1'b0; BRDT = 32'h3C3C_3C3C;
        for (int c = 0; c < 40 && n < 10; c++) begin
            @(negedge clk);
            if (i_valid && d_valid) begin
                both++;
            end else if (i_valid || d_valid) begin
                total++;
                if (i_valid !== exp_i[n]) begin
                    bad++;
                    $display("FAIL streak_order grant=%0d got_fetch=%b exp_fetch=%b", n, i_valid, exp_i[n]);
                end
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0; BACK_n = 1'b1;
        total++;
        if (n !== 10) begin
            bad++;
            $display("FAIL streak_count got=%0d exp=10", n);
        end
        total++;
        if (both !== 0) begin
            bad++;
            $display("FAIL streak_dual_valid got=%0d exp=0", both);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; BACK_n = 1'b1;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (d_valid) seen = 1'b1;
            else k++;
        end
        total++;
        if (k !== 255) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d exp=255", k);
        end
        total++;
        if ({d_valid, err, BREQ} !== 3'b110 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL timeout_abort got=%b/%h exp=110/00000000", {d_valid, err, BREQ}, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({d_valid, err} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_pulse_end got=%b exp=00", {d_valid, err});
        end
        d_req = 1'b1; d_addr = 32'h0000_0204;
        @(negedge clk);
        BACK_n = 1'b0; BRDT = 32'h0BAD_F00D;
        @(negedge clk);
        total++;
        if ({d_valid, err} !== 2'b10 || d_rdata !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL timeout_recover got=%b/%h exp=10/0badf00d", {d_valid, err}, d_rdata);
        end
        d_req = 1'b0; BACK_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack_at_timeout();
        int early;
        early = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0208; BACK_n = 1'b1;
        for (int c = 0; c < 255; c++) begin
            @(negedge clk);
            if (d_valid) early++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL edge_early_valid got=%0d exp=0", early);
        end
        BACK_n = 1'b0; BRDT = 32'h5A5A_0001;
        @(negedge clk);
        total++;
        if ({d_valid, err} !== 2'b10 || d_rdata !== 32'h5A5A_0001) begin
            bad++;
            $display("FAIL edge_ack_wins got=%b/%h exp=10/5a5a0001", {d_valid, err}, d_rdata);
        end
        d_req = 1'b0; BACK_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        int spur;
        spur = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        @(negedge clk);
        total++;
        if (BREQ !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_grant got=%b exp=1", BREQ);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({BREQ, BWRITE, BSIZE, i_valid, d_valid, err} !== 7'b0 ||
            {BAD, BWDT, i_rdata, d_rdata} !== 128'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b/%h exp=0/0",
                     {BREQ, BWRITE, BSIZE, i_valid, d_valid, err}, {BAD, BWDT, i_rdata, d_rdata});
        end
        rst = 1'b0; d_req = 1'b0; BACK_n = 1'b0; BRDT = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d_valid || i_valid || BREQ) spur++;
        end
        total++;
        if (spur !== 0 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_idle_ack_ignored got=%0d/%h exp=0/00000000", spur, d_rdata);
        end
        BACK_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fetch();
        test_load_delayed_ack();
        test_store_byte();
        test_streak();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus (address, request, write, size, data, active-low ack) between the instruction-fetch port and the load/store port of the core.
- Data accesses win by default; a streak limit guarantees fetch progress.
- Sequences each transfer through an ack-handshake state machine with a timeout watchdog.
- Sits between the datapath memory stages and the top-level bus pins.

Parameters:
- BIT_WIDTH, 32, address/data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending
- TIMEOUT, 255, bus cycles waited for ack before aborting (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held until i_valid
- i_addr  in  BIT_WIDTH  fetch address
- i_rdata  out  BIT_WIDTH  fetched word
- i_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  load/store request; held until d_valid
- d_we  in  1  1 = store
- d_size  in  2  00 word, 01 half, 10 byte
- d_addr  in  BIT_WIDTH  data address
- d_wdata  in  BIT_WIDTH  store data, right-aligned
- d_rdata  out  BIT_WIDTH  load data, as returned by bus (right-aligned, zero-extended)
- d_valid  out  1  one-cycle completion pulse for data
- err  out  1  one-cycle pulse coincident with a valid that ended by timeout
- BAD  out  BIT_WIDTH  bus address
- BREQ  out  1  bus request
- BWRITE  out  1  bus write
- BSIZE  out  2  bus size; 00 for fetches
- BWDT  out  BIT_WIDTH  bus write data
- BRDT  in  BIT_WIDTH  bus read data
- BACK_n  in  1  bus ack, active low

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; streak counter 0; timeout counter 0.
  - Reset asserted in any state aborts the transfer: BREQ=0 next edge, no valid pulse.
- State IDLE:
  - Evaluates requests each cycle.
  - d_req only -> DBUS. i_req only -> IBUS. Neither -> stay.
  - Both: DBUS if streak < MAX_D_STREAK, else IBUS.
  - On leaving IDLE, the chosen request's addr/size/we/wdata are registered onto BAD/BSIZE/BWRITE/BWDT and BREQ=1 at the same edge.
- States IBUS / DBUS:
  - Bus signals held stable; requester inputs ignored.
  - BACK_n sampled each rising edge.
  - BACK_n=0: capture BRDT (loads/fetches only), pulse the matching valid next cycle, drop BREQ, clear BWRITE, return to IDLE.
  - Stores: d_rdata unchanged.
- Latency:
  - Request seen in IDLE at edge T; bus driven after T.
  - Ack sampled earliest at T+1; valid high in cycle after that edge.
  - Minimum 2 cycles request->valid.
  - One IDLE cycle between transfers (bus idles >=1 cycle).
- Streak counter:
  - Increments on each DBUS grant made while i_req=1, saturating at MAX_D_STREAK.
  - Clears on any IBUS grant, or a DBUS grant with i_req=0.
- Timeout:
  - Counter clears on grant and increments each cycle in IBUS/DBUS with BACK_n=1.
  - On reaching TIMEOUT: abort, rdata of that port <= 0, valid and err pulse together, return to IDLE.
  - Ack and timeout on the same edge -> ack wins, err=0.
- Valid pulses:
  - i_valid and d_valid never high together.
  - Valid is high exactly one cycle per grant.
  - A requester holding req after valid is re-arbitrated as a new request.
- BACK_n low while in IDLE is ignored.
- No address decode; STDOUT/EXIT handling remains at bus level.

Test Plan:
- Fetch only, i_addr=0x0000_0010, ack 1 cycle after BREQ -> BAD=0x10, BSIZE=00, BWRITE=0; i_valid one cycle with i_rdata=BRDT=0x2008_0001; BREQ low next cycle.
- Store byte d_addr=0xF000_0000, d_wdata=0x41, d_size=10 -> BWRITE=1, BSIZE=10, BWDT=0x41; d_valid pulses; d_rdata unchanged.
- i_req and d_req held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no two valids in the same cycle.
- BACK_n never asserted, TIMEOUT=255 -> after 255 bus cycles d_valid=1, err=1, d_rdata=0; BREQ drops; next request proceeds normally.
- rst pulsed mid-DBUS with ack 3 cycles pending -> BREQ=0 and all outputs 0 after the rst edge; no d_valid; later ack ignored in IDLE.
- Ack on the exact TIMEOUT edge -> valid with captured BRDT, err=0.
